// File: rtl/instr_buff_responder.sv
// Responder side of the fetch-to-instruction-buffer interface.
// Queues fetch requests, issues one instruction-memory read at a time,
// returns each fetched word with its tag, and supports per-wavefront flush.
module instr_buff_responder #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 39,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  buff_rd_en,
    input  logic [ADDR_WIDTH-1:0] buff_addr,
    input  logic [TAG_WIDTH-1:0]  buff_tag,
    output logic                  buff_ack,
    input  logic                  flush_en,
    input  logic [5:0]            flush_wfid,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [TAG_WIDTH-1:0]  instr_tag,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  queue_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DEPTH-1:0]      qv_q, qv_d;
    logic [ADDR_WIDTH-1:0] qa_q [DEPTH];
    logic [ADDR_WIDTH-1:0] qa_d [DEPTH];
    logic [TAG_WIDTH-1:0]  qt_q [DEPTH];
    logic [TAG_WIDTH-1:0]  qt_d [DEPTH];
    logic [ADDR_WIDTH-1:0] fa_q, fa_d;
    logic [TAG_WIDTH-1:0]  ft_q, ft_d;
    logic                  kill_q, kill_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  buff_ack_q, buff_ack_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [DATA_WIDTH-1:0] instr_data_q, instr_data_d;
    logic [TAG_WIDTH-1:0]  instr_tag_q, instr_tag_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  queue_full_q, queue_full_d;

    logic [DEPTH-1:0]      flush_hit;
    logic                  inflight_hit;
    logic                  head_live;
    logic                  accept;
    logic                  pop;

    // Next-state logic: acceptance, flush invalidation, memory FSM and queue pointers.
    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        qa_d          = qa_q;
        qt_d          = qt_q;
        fa_d          = fa_q;
        ft_d          = ft_q;
        kill_d        = kill_q;
        rdata_d       = rdata_q;
        mem_addr_d    = mem_addr_q;
        instr_data_d  = instr_data_q;
        instr_tag_d   = instr_tag_q;
        instr_pc_d    = instr_pc_q;
        mem_rd_en_d   = 1'b0;
        instr_valid_d = 1'b0;
        pop           = 1'b0;

        // A held request is never taken twice: the ack cycle masks buff_rd_en.
        accept     = buff_rd_en && (count_q != CNT_W'(DEPTH)) && !buff_ack_q;
        buff_ack_d = accept;

        for (int i = 0; i < DEPTH; i++) begin
            flush_hit[i] = flush_en && (qt_q[i][5:0] == flush_wfid);
            qv_d[i]      = qv_q[i] && !flush_hit[i];
        end
        inflight_hit = flush_en && (ft_q[5:0] == flush_wfid);
        // A flush on the pop edge already counts against the head entry.
        head_live    = qv_q[head_q] && !flush_hit[head_q];

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head_live) begin
                        fa_d        = qa_q[head_q];
                        ft_d        = qt_q[head_q];
                        kill_d      = 1'b0;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = qa_q[head_q];
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (inflight_hit) kill_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (inflight_hit) kill_d = 1'b1;
                if (mem_ack) begin
                    rdata_d = mem_rd_data;
                    state_d = (kill_q || inflight_hit) ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (!inflight_hit) begin
                    instr_valid_d = 1'b1;
                    instr_data_d  = rdata_q;
                    instr_tag_d   = ft_q;
                    instr_pc_d    = fa_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            qv_d[head_q] = 1'b0;
            head_d       = head_q + 1'b1;
        end
        // The newly accepted entry is written after flush so it survives a same-edge flush.
        if (accept) begin
            qv_d[tail_q] = 1'b1;
            qa_d[tail_q] = buff_addr;
            qt_d[tail_q] = buff_tag;
            tail_d       = tail_q + 1'b1;
        end

        count_d      = count_q + CNT_W'(accept) - CNT_W'(pop);
        queue_full_d = (count_d == CNT_W'(DEPTH));
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            qv_q          <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                qa_q[i] <= '0;
                qt_q[i] <= '0;
            end
            fa_q          <= '0;
            ft_q          <= '0;
            kill_q        <= 1'b0;
            rdata_q       <= '0;
            buff_ack_q    <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_tag_q   <= '0;
            instr_pc_q    <= '0;
            queue_full_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            qv_q          <= qv_d;
            qa_q          <= qa_d;
            qt_q          <= qt_d;
            fa_q          <= fa_d;
            ft_q          <= ft_d;
            kill_q        <= kill_d;
            rdata_q       <= rdata_d;
            buff_ack_q    <= buff_ack_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_addr_q    <= mem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            instr_tag_q   <= instr_tag_d;
            instr_pc_q    <= instr_pc_d;
            queue_full_q  <= queue_full_d;
        end
    end

    assign buff_ack    = buff_ack_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr_data  = instr_data_q;
    assign instr_tag   = instr_tag_q;
    assign instr_pc    = instr_pc_q;
    assign queue_full  = queue_full_q;

endmodule

// File: tb/tb_instr_buff_responder.sv
// Bench for instr_buff_responder: cycle table, directed sequences and
// randomized traffic checked against an in-order expected-transaction model.
module tb_instr_buff_responder;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int TW    = 39;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          buff_rd_en;
    logic [AW-1:0] buff_addr;
    logic [TW-1:0] buff_tag;
    logic          buff_ack;
    logic          flush_en;
    logic [5:0]    flush_wfid;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rd_data;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic [TW-1:0] instr_tag;
    logic [AW-1:0] instr_pc;
    logic          queue_full;

    instr_buff_responder #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .buff_rd_en(buff_rd_en), .buff_addr(buff_addr), .buff_tag(buff_tag), .buff_ack(buff_ack),
        .flush_en(flush_en), .flush_wfid(flush_wfid),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_tag(instr_tag), .instr_pc(instr_pc),
        .queue_full(queue_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [TW-1:0] tag;
    } req_t;

    typedef struct {
        logic          rd;
        logic [AW-1:0] addr;
        logic [TW-1:0] tag;
        logic          fl;
        logic [5:0]    fwid;
        logic          mack;
        logic [DW-1:0] mdata;
        logic          e_ack;
        logic          e_mrd;
        logic [AW-1:0] e_maddr;
        logic          e_iv;
        logic [DW-1:0] e_idata;
        logic [TW-1:0] e_itag;
        logic [AW-1:0] e_ipc;
        logic          e_full;
    } vec_t;

    int checks = 0;
    int errors = 0;

    req_t req_q[$];
    req_t exp_fetch[$];
    req_t exp_ret[$];
    req_t cur;
    bit            req_active;
    bit            auto_exp;
    int            gap_max, gap_cnt;
    int            lat_min, lat_max;
    bit            pend;
    int            pend_cnt;
    logic [AW-1:0] pend_addr;
    bit            prev_full, saw_full;
    int            n_acks, n_reads, n_rets;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Memory contents as seen by the bench: a fixed scramble of the address.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_buff_ack"}, buff_ack, 0);
        chk({pfx, "_mem_rd_en"}, mem_rd_en, 0);
        chk({pfx, "_mem_addr"}, mem_addr, 0);
        chk({pfx, "_instr_valid"}, instr_valid, 0);
        chk({pfx, "_instr_data"}, instr_data, 0);
        chk({pfx, "_instr_tag"}, instr_tag, 0);
        chk({pfx, "_instr_pc"}, instr_pc, 0);
        chk({pfx, "_queue_full"}, queue_full, 0);
    endtask

    // One clock: observe outputs, run memory model and requester, drive next inputs.
    task automatic step();
        req_t e;
        @(posedge clk);
        #1;
        flush_en = 1'b0;
        if (prev_full) chk("no_ack_when_full", buff_ack, 0);
        prev_full = queue_full;
        if (queue_full) saw_full = 1;

        if (buff_ack) begin
            n_acks++;
            chk("ack_has_request", req_active, 1);
            req_active = 0;
        end

        mem_ack = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_ack     = 1'b1;
                mem_rd_data = mem_word(pend_addr);
                pend        = 0;
            end
        end
        if (mem_rd_en) begin
            n_reads++;
            chk("one_outstanding", pend, 0);
            chk("read_expected", exp_fetch.size() != 0, 1);
            if (exp_fetch.size() != 0) begin
                e = exp_fetch.pop_front();
                chk("mem_addr", mem_addr, e.addr);
            end
            pend      = 1;
            pend_cnt  = $urandom_range(lat_max, lat_min);
            pend_addr = mem_addr;
        end

        if (instr_valid) begin
            n_rets++;
            chk("ret_expected", exp_ret.size() != 0, 1);
            if (exp_ret.size() != 0) begin
                e = exp_ret.pop_front();
                chk("instr_pc", instr_pc, e.addr);
                chk("instr_tag", instr_tag, e.tag);
                chk("instr_data", instr_data, mem_word(e.addr));
            end
        end

        if (!req_active && req_q.size() != 0) begin
            if (gap_cnt > 0) gap_cnt--;
            else begin
                cur        = req_q.pop_front();
                req_active = 1;
                buff_addr  = cur.addr;
                buff_tag   = cur.tag;
                if (auto_exp) begin
                    exp_fetch.push_back(cur);
                    exp_ret.push_back(cur);
                end
                gap_cnt = $urandom_range(gap_max, 0);
            end
        end
        buff_rd_en = req_active;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        while ((req_q.size() != 0 || req_active || exp_ret.size() != 0 || pend) && n < budget) begin
            step();
            n++;
        end
        chk({name, "_completed"}, n < budget, 1);
        repeat (4) step();
    endtask

    task automatic clear_stats();
        n_acks = 0; n_reads = 0; n_rets = 0; saw_full = 0;
    endtask

    vec_t tv[12];
    req_t r;

    initial begin
        logic [6:0]  thi;
        logic [31:0] tlo;
        int          n;

        rst = 1'b0; buff_rd_en = 0; buff_addr = 0; buff_tag = 0; flush_en = 0; flush_wfid = 0;
        mem_ack = 0; mem_rd_data = 0;
        req_active = 0; auto_exp = 1; gap_max = 0; gap_cnt = 0; lat_min = 1; lat_max = 1;
        pend = 0; pend_cnt = 0; pend_addr = 0; prev_full = 0;
        clear_stats();

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Cycle table: single fetch, held request during ack, same-edge accept+flush.
        tv[0]  = '{1, 32'h18, 39'h5, 0, 6'd0, 0, 32'h0,        1, 0, 32'h0,  0, 32'h0,        39'h5, 32'h0,  0};
        tv[0].e_itag = 39'h0;
        tv[1]  = '{1, 32'h18, 39'h5, 0, 6'd0, 0, 32'h0,        0, 1, 32'h18, 0, 32'h0,        39'h0, 32'h0,  0};
        tv[2]  = '{0, 32'h0,  39'h0, 0, 6'd0, 0, 32'h0,        0, 0, 32'h18, 0, 32'h0,        39'h0, 32'h0,  0};
        tv[3]  = '{0, 32'h0,  39'h0, 0, 6'd0, 1, 32'hBF810000, 0, 0, 32'h18, 0, 32'h0,        39'h0, 32'h0,  0};
        tv[4]  = '{0, 32'h0,  39'h0, 0, 6'd0, 0, 32'h0,        0, 0, 32'h18, 1, 32'hBF810000, 39'h5, 32'h18, 0};
        tv[5]  = '{0, 32'h0,  39'h0, 0, 6'd0, 0, 32'h0,        0, 0, 32'h18, 0, 32'hBF810000, 39'h5, 32'h18, 0};
        tv[6]  = '{1, 32'h30, 39'h0A50000040, 1, 6'd0, 0, 32'h0, 1, 0, 32'h18, 0, 32'hBF810000, 39'h5, 32'h18, 0};
        tv[7]  = '{0, 32'h0,  39'h0, 0, 6'd0, 0, 32'h0,        0, 1, 32'h30, 0, 32'hBF810000, 39'h5, 32'h18, 0};
        tv[8]  = '{0, 32'h0,  39'h0, 0, 6'd0, 0, 32'h0,        0, 0, 32'h30, 0, 32'hBF810000, 39'h5, 32'h18, 0};
        tv[9]  = '{0, 32'h0,  39'h0, 0, 6'd0, 1, 32'h12345678, 0, 0, 32'h30, 0, 32'hBF810000, 39'h5, 32'h18, 0};
        tv[10] = '{0, 32'h0,  39'h0, 0, 6'd0, 0, 32'h0,        0, 0, 32'h30, 1, 32'h12345678, 39'h0A50000040, 32'h30, 0};
        tv[11] = '{0, 32'h0,  39'h0, 0, 6'd0, 0, 32'h0,        0, 0, 32'h30, 0, 32'h12345678, 39'h0A50000040, 32'h30, 0};

        for (int i = 0; i < 12; i++) begin
            buff_rd_en = tv[i].rd; buff_addr = tv[i].addr; buff_tag = tv[i].tag;
            flush_en = tv[i].fl; flush_wfid = tv[i].fwid;
            mem_ack = tv[i].mack; mem_rd_data = tv[i].mdata;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_buff_ack", i), buff_ack, tv[i].e_ack);
            chk($sformatf("row%0d_mem_rd_en", i), mem_rd_en, tv[i].e_mrd);
            chk($sformatf("row%0d_mem_addr", i), mem_addr, tv[i].e_maddr);
            chk($sformatf("row%0d_instr_valid", i), instr_valid, tv[i].e_iv);
            chk($sformatf("row%0d_instr_data", i), instr_data, tv[i].e_idata);
            chk($sformatf("row%0d_instr_tag", i), instr_tag, tv[i].e_itag);
            chk($sformatf("row%0d_instr_pc", i), instr_pc, tv[i].e_ipc);
            chk($sformatf("row%0d_queue_full", i), queue_full, tv[i].e_full);
        end
        buff_rd_en = 0; flush_en = 0; mem_ack = 0;

        // Backpressure: six back-to-back requests, slow memory.
        clear_stats(); auto_exp = 1; gap_max = 0; lat_min = 10; lat_max = 10;
        for (int i = 0; i < 6; i++) begin
            r.addr = 32'(4 * i); r.tag = 39'h7F00000000 | 39'(i + 8);
            req_q.push_back(r);
        end
        run_until_idle("backpressure", 400);
        chk("bp_saw_full", saw_full, 1);
        chk("bp_acks", n_acks, 6);
        chk("bp_reads", n_reads, 6);
        chk("bp_returns", n_rets, 6);

        // Flush of queued and in-flight wfid0 entries while the first read waits.
        clear_stats(); auto_exp = 0; gap_max = 0; lat_min = 10; lat_max = 10;
        r.addr = 32'h0;   r.tag = 39'h1234000000; req_q.push_back(r); exp_fetch.push_back(r);
        r.addr = 32'h4;   r.tag = 39'h1234000080; req_q.push_back(r);
        r.addr = 32'h100; r.tag = 39'h5678000001; req_q.push_back(r);
        exp_fetch.push_back(r); exp_ret.push_back(r);
        n = 0;
        while (n_acks < 3 && n < 50) begin step(); n++; end
        chk("flush_setup_acks", n_acks, 3);
        flush_en = 1'b1; flush_wfid = 6'd0;
        step();
        run_until_idle("flush", 200);
        chk("flush_reads", n_reads, 2);
        chk("flush_returns", n_rets, 1);

        // Pointer wrap: 3*DEPTH requests with short mixed latencies.
        clear_stats(); auto_exp = 1; gap_max = 0; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            r.addr = 32'h1000 + 32'(4 * i); r.tag = 39'(i * 3 + 7);
            req_q.push_back(r);
        end
        run_until_idle("wrap", 400);
        chk("wrap_returns", n_rets, 3 * DEPTH);
        chk("wrap_queue_full_end", queue_full, 0);

        // Randomized traffic.
        clear_stats(); auto_exp = 1; gap_max = 3; lat_min = 1; lat_max = 6;
        for (int i = 0; i < 40; i++) begin
            thi = 7'($urandom); tlo = $urandom;
            r.addr = $urandom & 32'hFFFF_FFFC; r.tag = {thi, tlo};
            req_q.push_back(r);
        end
        run_until_idle("random", 2000);
        chk("rand_acks", n_acks, 40);
        chk("rand_returns", n_rets, 40);
        chk("rand_queue_full_end", queue_full, 0);

        // Reset while a read is outstanding, then a stray memory ack.
        clear_stats(); auto_exp = 0; gap_max = 0; lat_min = 20; lat_max = 20;
        r.addr = 32'h200; r.tag = 39'h2A; req_q.push_back(r); exp_fetch.push_back(r);
        n = 0;
        while (n_reads < 1 && n < 20) begin step(); n++; end
        chk("rst_setup_read", n_reads, 1);
        step(); step();
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        pend = 0; req_active = 0; buff_rd_en = 0; mem_ack = 0;
        req_q.delete(); exp_fetch.delete(); exp_ret.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        mem_ack = 1'b1; mem_rd_data = 32'hDEADBEEF;
        step();
        repeat (4) step();
        chk("rst_no_instr", n_rets, 0);
        chk_all_zero("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
